// File: rtl/vt52_pkg.sv
// Shared definitions for the VT52-style terminal datapath: screen geometry,
// fill byte, scroll/clear command encodings and the fill FSM states.
package vt52_pkg;

    localparam int ROWS         = 24;
    localparam int COLS         = 80;
    localparam int ROW_BITS     = 5;
    localparam int COL_BITS     = 7;
    localparam int ADDR_BITS    = 11;
    localparam int SCREEN_CHARS = ROWS * COLS;

    localparam logic [7:0] FILL_CHAR = 8'h20;

    localparam logic [1:0] CMD_SCROLL_UP    = 2'd0;
    localparam logic [1:0] CMD_CLEAR_SCREEN = 2'd1;
    localparam logic [1:0] CMD_CLEAR_EOL    = 2'd2;
    localparam logic [1:0] CMD_CLEAR_EOS    = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } fill_state_e;

endpackage

// File: rtl/screen_addr.sv
// Maps a screen-relative (x,y) to a circular character-buffer address:
// (first + y*COLS + x) mod ROWS*COLS using one conditional subtraction.
module screen_addr
    import vt52_pkg::*;
#(
    parameter int ROWS      = vt52_pkg::ROWS,
    parameter int COLS      = vt52_pkg::COLS,
    parameter int ROW_BITS  = vt52_pkg::ROW_BITS,
    parameter int COL_BITS  = vt52_pkg::COL_BITS,
    parameter int ADDR_BITS = vt52_pkg::ADDR_BITS
) (
    input  logic [ADDR_BITS-1:0] i_first,
    input  logic [COL_BITS-1:0]  i_x,
    input  logic [ROW_BITS-1:0]  i_y,
    output logic [ADDR_BITS-1:0] o_addr
);

    localparam int N_CHARS  = ROWS * COLS;
    // Two spare bits so out-of-range cursors cannot overflow the sum.
    localparam int SUM_BITS = ADDR_BITS + 2;

    logic [SUM_BITS-1:0] w_sum;

    assign w_sum  = SUM_BITS'(i_first) + SUM_BITS'(i_y) * SUM_BITS'(COLS) + SUM_BITS'(i_x);
    assign o_addr = (w_sum >= SUM_BITS'(N_CHARS)) ? ADDR_BITS'(w_sum - SUM_BITS'(N_CHARS))
                                                  : ADDR_BITS'(w_sum);

endmodule

// File: rtl/scroll_clear_engine.sv
// Owns the scroll pointer (first_char) and bulk-writes the fill character
// into the character buffer for scroll-up and the clear commands.
module scroll_clear_engine
    import vt52_pkg::*;
#(
    parameter int         ROWS      = vt52_pkg::ROWS,
    parameter int         COLS      = vt52_pkg::COLS,
    parameter int         ROW_BITS  = vt52_pkg::ROW_BITS,
    parameter int         COL_BITS  = vt52_pkg::COL_BITS,
    parameter int         ADDR_BITS = vt52_pkg::ADDR_BITS,
    parameter logic [7:0] FILL_CHAR = vt52_pkg::FILL_CHAR
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd,
    input  logic [COL_BITS-1:0]  cursor_x,
    input  logic [ROW_BITS-1:0]  cursor_y,
    output logic [ADDR_BITS-1:0] first_char,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [7:0]           wr_data,
    output logic                 wr_en,
    output logic                 busy
);

    localparam int N_CHARS = ROWS * COLS;

    fill_state_e            r_state;
    fill_state_e            w_next_state;
    logic [ADDR_BITS-1:0]   r_first_char;
    logic [ADDR_BITS-1:0]   r_wr_addr;
    logic [ADDR_BITS-1:0]   r_count;
    logic [7:0]             r_wr_data;
    logic                   r_wr_en;
    logic                   r_cmd_ready;
    logic                   r_busy;

    logic [ADDR_BITS-1:0]   w_next_first;
    logic [ADDR_BITS-1:0]   w_next_addr;
    logic [ADDR_BITS-1:0]   w_next_count;
    logic                   w_next_wr_en;
    logic                   w_next_ready;

    logic                   w_accept;
    logic                   w_cursor_ok;
    logic [ADDR_BITS-1:0]   w_cursor_addr;
    logic [ADDR_BITS-1:0]   w_lin_off;
    logic [ADDR_BITS-1:0]   w_scroll_first;
    logic [ADDR_BITS-1:0]   w_addr_inc;
    logic [ADDR_BITS-1:0]   w_cmd_start;
    logic [ADDR_BITS-1:0]   w_cmd_count;
    logic [ADDR_BITS-1:0]   w_cmd_first;

    assign w_accept    = cmd_valid & r_cmd_ready;
    assign w_cursor_ok = (32'(cursor_x) < 32'(COLS)) && (32'(cursor_y) < 32'(ROWS));

    screen_addr #(
        .ROWS(ROWS), .COLS(COLS), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .ADDR_BITS(ADDR_BITS)
    ) u_cursor_addr (
        .i_first (r_first_char),
        .i_x     (cursor_x),
        .i_y     (cursor_y),
        .o_addr  (w_cursor_addr)
    );

    // With a zero origin the same mapping yields the linear offset y*COLS+x.
    screen_addr #(
        .ROWS(ROWS), .COLS(COLS), .ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .ADDR_BITS(ADDR_BITS)
    ) u_lin_off (
        .i_first ({ADDR_BITS{1'b0}}),
        .i_x     (cursor_x),
        .i_y     (cursor_y),
        .o_addr  (w_lin_off)
    );

    assign w_scroll_first = (r_first_char >= ADDR_BITS'(N_CHARS - COLS))
                          ? r_first_char - ADDR_BITS'(N_CHARS - COLS)
                          : r_first_char + ADDR_BITS'(COLS);
    assign w_addr_inc     = (r_wr_addr == ADDR_BITS'(N_CHARS - 1)) ? {ADDR_BITS{1'b0}}
                                                                    : r_wr_addr + {{(ADDR_BITS-1){1'b0}}, 1'b1};

    // Command decode: fill start, fill length and new scroll origin.
    always_comb begin
        w_cmd_start = {ADDR_BITS{1'b0}};
        w_cmd_count = {ADDR_BITS{1'b0}};
        w_cmd_first = r_first_char;
        case (cmd)
            CMD_SCROLL_UP: begin
                w_cmd_start = r_first_char;
                w_cmd_count = ADDR_BITS'(COLS);
                w_cmd_first = w_scroll_first;
            end
            CMD_CLEAR_SCREEN: begin
                w_cmd_count = ADDR_BITS'(N_CHARS);
                w_cmd_first = {ADDR_BITS{1'b0}};
            end
            CMD_CLEAR_EOL: begin
                w_cmd_start = w_cursor_addr;
                if (w_cursor_ok) begin
                    w_cmd_count = ADDR_BITS'(COLS) - ADDR_BITS'(cursor_x);
                end else begin
                    w_cmd_count = {ADDR_BITS{1'b0}};
                end
            end
            CMD_CLEAR_EOS: begin
                w_cmd_start = w_cursor_addr;
                if (w_cursor_ok) begin
                    w_cmd_count = ADDR_BITS'(N_CHARS) - w_lin_off;
                end else begin
                    w_cmd_count = {ADDR_BITS{1'b0}};
                end
            end
            default: begin
                w_cmd_count = {ADDR_BITS{1'b0}};
            end
        endcase
    end

    // Next-state logic; r_count holds the writes still to show, including the current one.
    always_comb begin
        w_next_state = r_state;
        w_next_first = r_first_char;
        w_next_addr  = r_wr_addr;
        w_next_count = r_count;
        w_next_wr_en = 1'b0;
        w_next_ready = r_cmd_ready;
        case (r_state)
            ST_IDLE: begin
                w_next_ready = 1'b1;
                if (w_accept) begin
                    w_next_first = w_cmd_first;
                    if (w_cmd_count != {ADDR_BITS{1'b0}}) begin
                        w_next_state = ST_FILL;
                        w_next_addr  = w_cmd_start;
                        w_next_count = w_cmd_count;
                        w_next_wr_en = 1'b1;
                        w_next_ready = 1'b0;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (r_count == {{(ADDR_BITS-1){1'b0}}, 1'b1}) begin
                    w_next_state = ST_IDLE;
                    w_next_count = {ADDR_BITS{1'b0}};
                    w_next_ready = 1'b1;
                end else begin
                    w_next_addr  = w_addr_inc;
                    w_next_count = r_count - {{(ADDR_BITS-1){1'b0}}, 1'b1};
                    w_next_wr_en = 1'b1;
                    w_next_ready = 1'b0;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_ready = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_first_char <= {ADDR_BITS{1'b0}};
            r_wr_addr    <= {ADDR_BITS{1'b0}};
            r_count      <= {ADDR_BITS{1'b0}};
            r_wr_data    <= FILL_CHAR;
            r_wr_en      <= 1'b0;
            r_cmd_ready  <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_first_char <= w_next_first;
            r_wr_addr    <= w_next_addr;
            r_count      <= w_next_count;
            r_wr_data    <= FILL_CHAR;
            r_wr_en      <= w_next_wr_en;
            r_cmd_ready  <= w_next_ready;
            r_busy       <= ~w_next_ready;
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign busy       = r_busy;
    assign first_char = r_first_char;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign wr_en      = r_wr_en;

endmodule

// File: doc/scroll_clear_engine.md
Name: scroll_clear_engine

Overview:
- Upstream neighbour of the 80x24 character/sync generator.
- Owns the `first_char` scroll pointer the generator consumes, and performs bulk writes of the fill character into the character buffer write port: scroll-up line clear, clear screen, clear to end of line, clear to end of screen.
- Commands come from the terminal command decoder over a valid/ready handshake; one character is written per clock.

Parameters:
- ROWS, 24, text rows on screen
- COLS, 80, characters per row
- ROW_BITS, 5, width of the cursor row index
- COL_BITS, 7, width of the cursor column index
- ADDR_BITS, 11, character buffer address width (must hold ROWS*COLS-1)
- FILL_CHAR, 8'h20, byte written by every clear operation

Ports:
- clk  in  1  system clock (single clock domain)
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  engine idle and able to accept a command
- cmd  in  2  0=SCROLL_UP, 1=CLEAR_SCREEN, 2=CLEAR_EOL, 3=CLEAR_EOS
- cursor_x  in  COL_BITS  cursor column, sampled at command accept
- cursor_y  in  ROW_BITS  cursor row (screen-relative), sampled at command accept
- first_char  out  ADDR_BITS  buffer address of the top-left visible character
- wr_addr  out  ADDR_BITS  character buffer write address
- wr_data  out  8  character buffer write data
- wr_en  out  1  write strobe, one write per asserted cycle
- busy  out  1  equals ~cmd_ready

Behaviour:
- Reset values:
  - cmd_ready=1, busy=0, first_char=0, wr_en=0, wr_addr=0, wr_data=FILL_CHAR.
  - FSM to IDLE.
  - Applies from any state; a fill in progress is aborted with no further writes.
- Handshake:
  - A command is accepted on a cycle with cmd_valid && cmd_ready.
  - cmd, cursor_x and cursor_y are registered on that edge.
  - cmd_ready is low from the cycle after acceptance until the cycle after the last write.
- FSM states:
  - IDLE: on accept, compute start address and count, then go to FILL. If count==0, stay in IDLE; cmd_ready stays high and the next command can be accepted the following cycle.
  - FILL: wr_en=1, wr_data=FILL_CHAR. On each cycle, wr_addr advances by 1 and the count decrements. When the last write issues, go to IDLE.
- Timing: the first write occurs the cycle after acceptance; total occupancy is count+1 cycles from the accept edge.
- Address wrap: all addresses are modulo ROWS*COLS. An increment from ROWS*COLS-1 wraps to 0, and start address sums use one conditional subtraction of ROWS*COLS. Screen address of (x,y) = (first_char + y*COLS + x) mod ROWS*COLS; the operand sum is always < 2*ROWS*COLS.
- SCROLL_UP:
  - On the accept edge, first_char <= (first_char+COLS) mod ROWS*COLS.
  - Then fill COLS chars starting at the old first_char, which is now the bottom row.
  - first_char changing mid-frame is harmless because the generator loads it only during vblank.
- CLEAR_SCREEN: on the accept edge, first_char <= 0; then fill ROWS*COLS chars from address 0.
- CLEAR_EOL: start at screen address (cursor_x,cursor_y); count = COLS-cursor_x.
- CLEAR_EOS: start at screen address (cursor_x,cursor_y); count = ROWS*COLS-(cursor_y*COLS+cursor_x). The fill wraps through address 0 when the visible region crosses it.
- Out-of-range cursor: if cursor_x>=COLS or cursor_y>=ROWS, CLEAR_EOL and CLEAR_EOS are accepted as no-ops (count 0). SCROLL_UP and CLEAR_SCREEN ignore the cursor.
- Busy commands: cmd_valid while busy is held off by cmd_ready=0; it is not lost if the source holds it.
- Outputs are registered; no combinational path from cmd_valid to wr_*.

Decomposition:
- Shared package `vt52_pkg`:
  - command encodings CMD_SCROLL_UP, CMD_CLEAR_SCREEN, CMD_CLEAR_EOL, CMD_CLEAR_EOS
  - FILL_CHAR
  - default ROWS/COLS, and SCREEN_CHARS = ROWS*COLS
  - FSM state enum
- One sub-module, `screen_addr`: combinational (first_char, x, y) -> wrapped buffer address, using the constant multiply by COLS and a single conditional subtract.
- The same mapping is reusable by the character writer.

Test Plan:
- Reset, then CLEAR_SCREEN -> first_char=0; 1920 consecutive writes of 8'h20 at addresses 0..1919; cmd_ready returns high on cycle 1921 after accept.
- first_char=0, SCROLL_UP -> first_char=80 on the accept edge; 80 writes at addresses 0..79; repeat 24 times -> first_char back to 0.
- first_char=1840 (reached by 23 scrolls), SCROLL_UP -> first_char=0; writes at addresses 1840..1919.
- first_char=1840, cursor (x=10,y=1), CLEAR_EOS:
  - start address = (1840+90) mod 1920 = 10
  - count = 1920-90 = 1830 writes, addresses 10..1839
- cursor (x=75,y=3), CLEAR_EOL with first_char=80 -> 5 writes at addresses 395..399. cursor_x=80, CLEAR_EOL -> no writes and cmd_ready stays high.
- reset asserted mid CLEAR_SCREEN fill -> wr_en=0 the next cycle; first_char=0; cmd_ready=1; no further writes.
